// File: rtl/piece_pkg.sv
// piece_pkg: shared rotation encodings, FSM states and mask rotation helper
package piece_pkg;

    localparam logic [1:0] ROT_0 = 2'd0;
    localparam logic [1:0] ROT_1 = 2'd1;
    localparam logic [1:0] ROT_2 = 2'd2;
    localparam logic [1:0] ROT_3 = 2'd3;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    // Source mask bit that lands on destination cell (x,y) after rotation
    function automatic int rot_index(int x, int y, logic [1:0] rot, int n);
        return rot == ROT_0 ? y * n + x :
               rot == ROT_1 ? (n - 1 - x) * n + y :
               rot == ROT_2 ? n * n - 1 - y * n - x :
                              x * n + (n - 1 - y);
    endfunction

endpackage

// File: rtl/piece_fit_checker_if.sv
// piece_fit_checker_if: request operands and result flags of the fit checker
interface piece_fit_checker_if #(
    parameter int FIELD_W = 20,
    parameter int FIELD_H = 20,
    parameter int BLK_N   = 4,
    parameter int POS_W   = 6
);
    logic                       start;
    logic [BLK_N*BLK_N-1:0]     block;
    logic [FIELD_W*FIELD_H-1:0] field;
    logic [POS_W-1:0]           pos_x;
    logic [POS_W-1:0]           pos_y;
    logic [1:0]                 rotate;
    logic                       busy;
    logic                       done;
    logic                       fit;
    logic                       collide;
    logic                       oob;

    modport master (output start, block, field, pos_x, pos_y, rotate,
                    input  busy, done, fit, collide, oob);
    modport slave  (input  start, block, field, pos_x, pos_y, rotate,
                    output busy, done, fit, collide, oob);
endinterface

// File: rtl/piece_row_eval.sv
// piece_row_eval: bounds and collision test for one rotated piece row
module piece_row_eval #(
    parameter int FIELD_W = 20,
    parameter int FIELD_H = 20,
    parameter int BLK_N   = 4,
    parameter int POS_W   = 6
) (
    input  logic [BLK_N-1:0]           mask_i,
    input  logic signed [POS_W:0]      fx_base_i,
    input  logic signed [POS_W:0]      fy_i,
    input  logic [FIELD_W*FIELD_H-1:0] field_i,
    output logic                       row_collide_o,
    output logic                       row_oob_o
);
    localparam int P1 = POS_W + 1;
    localparam int IW = $clog2(FIELD_W * FIELD_H);
    localparam logic signed [P1-1:0] W_S = P1'(FIELD_W);
    localparam logic signed [P1-1:0] H_S = P1'(FIELD_H);

    logic [BLK_N-1:0] collide_v;
    logic [BLK_N-1:0] oob_v;
    logic             fy_low;
    logic             fy_in;

    // Rows above the top edge are free; rows below the floor are illegal
    assign fy_low = !fy_i[P1-1] && fy_i >= H_S;
    assign fy_in  = !fy_i[P1-1] && fy_i < H_S;

    for (genvar x = 0; x < BLK_N; x++) begin : g_cell
        logic signed [P1-1:0] fx;
        logic                 in_range;
        logic [IW-1:0]        idx;
        assign fx       = fx_base_i + P1'(x);
        assign in_range = fy_in && !fx[P1-1] && fx < W_S;
        // Address forced to zero unless in range so the field is never over-indexed
        assign idx          = in_range ? IW'(int'(fy_i) * FIELD_W + int'(fx)) : '0;
        assign collide_v[x] = mask_i[x] && in_range && field_i[idx];
        assign oob_v[x]     = mask_i[x] && (fx[P1-1] || fx >= W_S || fy_low);
    end

    assign row_collide_o = |collide_v;
    assign row_oob_o     = |oob_v;
endmodule

// File: rtl/piece_fit_checker.sv
// piece_fit_checker: row-serial collision and bounds check of a rotated piece
module piece_fit_checker
    import piece_pkg::*;
#(
    parameter int FIELD_W = 20,
    parameter int FIELD_H = 20,
    parameter int BLK_N   = 4,
    parameter int POS_W   = 6
) (
    input logic clk,
    input logic rst_n,
    piece_fit_checker_if.slave bus
);
    localparam int P1 = POS_W + 1;
    localparam int MW = $clog2(BLK_N * BLK_N);
    localparam int RW = BLK_N > 1 ? $clog2(BLK_N) : 1;

    state_t                     state_q, state_d;
    logic [BLK_N*BLK_N-1:0]     block_q;
    logic [FIELD_W*FIELD_H-1:0] field_q;
    logic [POS_W-1:0]           pos_x_q, pos_y_q;
    logic [1:0]                 rot_q;
    logic [RW-1:0]              r_q;
    logic                       collide_q, oob_q, fit_q;
    logic                       collide_d, oob_d;
    logic [BLK_N-1:0]           row_bits;
    logic signed [P1-1:0]       fx_base, fy;
    logic                       row_collide, row_oob, last, accept;

    assign fx_base   = {pos_x_q[POS_W-1], pos_x_q};
    assign fy        = {pos_y_q[POS_W-1], pos_y_q} + P1'(r_q);
    assign last      = r_q == RW'(BLK_N - 1);
    assign accept    = state_q == IDLE && bus.start;
    assign collide_d = collide_q | row_collide;
    assign oob_d     = oob_q | row_oob;

    // Gather the rotated mask bits of the current piece row
    always_comb begin
        row_bits = '0;
        for (int x = 0; x < BLK_N; x++)
            row_bits[x] = block_q[MW'(rot_index(x, int'(r_q), rot_q, BLK_N))];
    end

    piece_row_eval #(
        .FIELD_W(FIELD_W), .FIELD_H(FIELD_H), .BLK_N(BLK_N), .POS_W(POS_W)
    ) u_row (
        .mask_i       (row_bits),
        .fx_base_i    (fx_base),
        .fy_i         (fy),
        .field_i      (field_q),
        .row_collide_o(row_collide),
        .row_oob_o    (row_oob)
    );

    // Next-state: accept in IDLE, scan BLK_N rows, one DONE cycle
    always_comb begin
        state_d = state_q;
        state_d = accept                    ? SCAN :
                  (state_q == SCAN && last) ? DONE :
                  (state_q == DONE)         ? IDLE : state_q;
    end

    // State, operand capture and sticky flag accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            block_q   <= '0;
            field_q   <= '0;
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            rot_q     <= '0;
            r_q       <= '0;
            collide_q <= 1'b0;
            oob_q     <= 1'b0;
            fit_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                block_q   <= bus.block;
                field_q   <= bus.field;
                pos_x_q   <= bus.pos_x;
                pos_y_q   <= bus.pos_y;
                rot_q     <= bus.rotate;
                r_q       <= '0;
                collide_q <= 1'b0;
                oob_q     <= 1'b0;
                fit_q     <= 1'b0;
            end else if (state_q == SCAN) begin
                r_q       <= r_q + 1'b1;
                collide_q <= collide_d;
                oob_q     <= oob_d;
                if (last)
                    fit_q <= ~(collide_d | oob_d);
            end
        end
    end

    assign bus.busy    = state_q == SCAN;
    assign bus.done    = state_q == DONE;
    assign bus.fit     = fit_q;
    assign bus.collide = collide_q;
    assign bus.oob     = oob_q;
endmodule

// File: tb/tb_piece_fit_checker.sv
// tb_piece_fit_checker: randomized check of piece_fit_checker against a cell-level model
module tb_piece_fit_checker;
    localparam int W = 20;
    localparam int H = 20;
    localparam int N = 4;
    localparam int PW = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    piece_fit_checker_if #(.FIELD_W(W), .FIELD_H(H), .BLK_N(N), .POS_W(PW)) bus ();

    piece_fit_checker #(.FIELD_W(W), .FIELD_H(H), .BLK_N(N), .POS_W(PW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One clockwise quarter turn of an N x N mask
    function automatic logic [N*N-1:0] turn(input logic [N*N-1:0] m);
        logic [N*N-1:0] t = '0;
        for (int y = 0; y < N; y++)
            for (int x = 0; x < N; x++)
                t[y*N+x] = m[(N-1-x)*N+y];
        return t;
    endfunction

    // Returns {fit, collide, oob}
    function automatic logic [2:0] model(input logic [N*N-1:0] b, input logic [W*H-1:0] f,
                                         input int px, input int py, input int rot);
        logic [N*N-1:0] m = b;
        logic c = 1'b0;
        logic o = 1'b0;
        for (int i = 0; i < rot; i++) m = turn(m);
        for (int y = 0; y < N; y++)
            for (int x = 0; x < N; x++)
                if (m[y*N+x]) begin
                    int fx = px + x;
                    int fy = py + y;
                    if (fx < 0 || fx >= W || fy >= H) o = 1'b1;
                    else if (fy >= 0 && f[fy*W+fx]) c = 1'b1;
                end
        return {~(c | o), c, o};
    endfunction

    int         mph = 0;
    logic [2:0] mres = '0;
    logic [2:0] mflags = '0;

    // Spec timeline: accepted start -> N busy cycles -> one done cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mph    <= 0;
            mflags <= '0;
        end else if (mph == 0) begin
            if (bus.start) begin
                mph    <= 1;
                mflags <= '0;
                mres   <= model(bus.block, bus.field, int'($signed(bus.pos_x)),
                                int'($signed(bus.pos_y)), int'(bus.rotate));
            end
        end else if (mph == N) begin
            mph    <= N + 1;
            mflags <= mres;
        end else if (mph == N + 1) begin
            mph <= 0;
        end else begin
            mph <= mph + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", int'(bus.busy), int'(mph >= 1 && mph <= N));
            chk("done", int'(bus.done), int'(mph == N + 1));
            if (mph == 0 || mph == N + 1)
                chk("flags", int'({bus.fit, bus.collide, bus.oob}), int'(mflags));
            else
                chk("fit_scan", int'(bus.fit), 0);
        end
    end

    task automatic scramble();
        bus.block  = 16'($urandom);
        bus.field  = {13{$urandom}};
        bus.pos_x  = 6'($urandom);
        bus.pos_y  = 6'($urandom);
        bus.rotate = 2'($urandom);
    endtask

    task automatic run(input logic [N*N-1:0] b, input logic [W*H-1:0] f, input int px,
                       input int py, input logic [1:0] r, output logic [2:0] res, output int lat);
        @(posedge clk);
        #2;
        bus.block  = b;
        bus.field  = f;
        bus.pos_x  = 6'(px);
        bus.pos_y  = 6'(py);
        bus.rotate = r;
        bus.start  = 1'b1;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        scramble();
        lat = 0;
        res = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = i;
                res = {bus.fit, bus.collide, bus.oob};
                break;
            end
        end
    endtask

    logic [W*H-1:0] fz, f42, fr;
    logic [2:0]     res;
    int             lat;

    initial begin
        fz = '0;
        f42 = '0;
        f42[42] = 1'b1;
        bus.start = 1'b0;
        scramble();
        #1 rst_n = 1'b0;
        #20;
        @(posedge clk);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;

        chk("model_O", int'(model(16'h0660, fz, 0, 0, 0)), 3'b100);
        chk("model_I_rot1", int'(model(16'h00F0, fz, 17, 0, 1)), 3'b100);

        run(16'h0660, fz, 0, 0, 2'd0, res, lat);
        chk("O_latency", lat, 5);
        chk("O_empty", int'(res), 3'b100);
        run(16'h0660, f42, 1, 1, 2'd0, res, lat);
        chk("O_collide", int'(res), 3'b010);
        run(16'h00F0, fz, 17, 0, 2'd0, res, lat);
        chk("I_oob", int'(res), 3'b001);
        run(16'h00F0, fz, 17, 0, 2'd1, res, lat);
        chk("I_rot1_fit", int'(res), 3'b100);
        run(16'h0660, fz, -1, -2, 2'd0, res, lat);
        chk("O_above_top", int'(res), 3'b100);
        run(16'h0660, fz, 0, 18, 2'd0, res, lat);
        chk("O_floor", int'(res), 3'b001);
        run(16'h0000, f42, -5, 25, 2'd3, res, lat);
        chk("empty_mask", int'(res), 3'b100);

        // Start pulse during a scan must be ignored
        @(posedge clk);
        #2;
        bus.block = 16'h0660; bus.field = fz; bus.pos_x = 6'd0; bus.pos_y = 6'd18;
        bus.rotate = 2'd0; bus.start = 1'b1;
        @(posedge clk);
        #2 bus.start = 1'b0;
        @(posedge clk);
        #2;
        bus.block = 16'h0000; bus.pos_y = 6'd0; bus.start = 1'b1;
        @(posedge clk);
        #2 bus.start = 1'b0;
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat++;
                res = {bus.fit, bus.collide, bus.oob};
            end
        end
        chk("midscan_done_count", lat, 1);
        chk("midscan_result", int'(res), 3'b001);

        // Reset in the middle of a scan
        @(posedge clk);
        #2;
        bus.block = 16'h0660; bus.field = fz; bus.pos_x = 6'd0; bus.pos_y = 6'd18;
        bus.start = 1'b1;
        @(posedge clk);
        #2 bus.start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_flags", int'({bus.fit, bus.collide, bus.oob}), 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) lat++;
        end
        chk("rst_no_done", lat, 0);
        run(16'h0660, f42, 1, 1, 2'd0, res, lat);
        chk("rst_fresh", int'(res), 3'b010);

        for (int t = 0; t < 60; t++) begin
            fr = '0;
            for (int i = 0; i < W * H; i++) fr[i] = ($urandom_range(0, 7) == 0);
            run(16'($urandom), fr, $urandom_range(0, 27) - 4, $urandom_range(0, 27) - 5,
                2'($urandom), res, lat);
            chk("rand_latency", lat, N + 1);
        end

        repeat (3) @(posedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/piece_fit_checker.md
Name: piece_fit_checker

Overview:
- Sequential, parametrised collision/bounds checker for the playfield.
- Given a BLK_N x BLK_N piece mask, a rotation, a signed anchor position and the field occupancy map, it decides whether the rotated piece fits.
- It scans one piece row per clock, so the wide AND-reduction is spread over BLK_N cycles.
- Sits between the game-control FSM (move/rotate/drop requests) and the field register; driven by a start/done handshake.

Parameters:
- FIELD_W, 20, playfield width in cells.
- FIELD_H, 20, playfield height in cells.
- BLK_N, 4, piece mask edge length (mask is BLK_N*BLK_N bits).
- POS_W, 6, width of the signed anchor coordinates (two's complement).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- block  in  BLK_N*BLK_N  piece mask; bit index = y*BLK_N + x in the unrotated frame.
- field  in  FIELD_W*FIELD_H  occupancy; bit index = y*FIELD_W + x; 1 = filled.
- pos_x  in  POS_W  signed anchor column of mask cell (0,0).
- pos_y  in  POS_W  signed anchor row of mask cell (0,0); y grows downward.
- rotate  in  2  rotation, 0..3 quarter turns.
- busy  out  1  high while a check is in progress.
- done  out  1  one-cycle pulse when the result is valid.
- fit  out  1  1 = piece fits (no collision, no out-of-bounds).
- collide  out  1  at least one set mask cell lands on a filled field cell.
- oob  out  1  at least one set mask cell lies outside the legal area.

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE.
  - busy, done, fit, collide and oob = 0.
  - Captured operands are cleared.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: when start=1, capture block, field, pos_x, pos_y and rotate; clear the sticky flags and the row counter; go to SCAN.
  - SCAN: busy=1. Each cycle, evaluate all BLK_N cells of piece row r (r = 0..BLK_N-1). When r = BLK_N-1, go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency: start sampled at edge 0 → done high during cycle BLK_N+1 (5 cycles for BLK_N=4). Throughput is one check per BLK_N+2 cycles.
- start while in SCAN or DONE is ignored; it is not queued. Operands are used only from the capture, so input changes after start have no effect.
- Rotation mapping (destination cell (x,y) reads source mask bit):
  - rot 0: y*N + x
  - rot 1: (N-1-x)*N + y
  - rot 2: N*N-1 - y*N - x
  - rot 3: x*N + (N-1-y)
- Cell test, only for cells whose rotated mask bit = 1:
  - fx = pos_x + x, fy = pos_y + y, computed sign-extended to POS_W+1 bits.
  - oob if fx < 0, fx >= FIELD_W, or fy >= FIELD_H.
  - fy < 0 (above the top edge) is legal and free; it never collides and never sets oob.
  - collide if the cell is in range (0 <= fx < FIELD_W, 0 <= fy < FIELD_H) and field[fy*FIELD_W+fx] = 1.
  - The field is never indexed with an out-of-range address; the guard is applied before indexing.
- Output flags:
  - collide and oob are sticky OR-accumulators over the scan.
  - fit = ~collide & ~oob, registered and updated on the DONE transition.
  - fit, collide and oob hold their values until the next accepted start, when they clear to 0.
  - An empty mask (block = 0) gives fit = 1.
- Reset mid-scan: immediate abort to IDLE with all outputs 0; no done pulse is issued.

Decomposition:
- Package piece_pkg holds:
  - The rotate encoding constants ROT_0..ROT_3.
  - The state enum {IDLE, SCAN, DONE}.
  - A function rot_index(x, y, rot, N) returning the source mask bit index.
- One sub-module, piece_row_eval: combinational evaluation of a single row.
  - Inputs: row mask bits, fx base, fy, field.
  - Outputs: row_collide, row_oob.
  - Instantiated once in the top level and reused every SCAN cycle.

Test Plan:
- Empty field, block=16'h0660 (O piece), rot 0, pos (0,0), start → done at cycle 5; fit=1, collide=0, oob=0.
- Same O piece, field bit 42 set (cell x2,y2), pos (1,1) → fit=0, collide=1, oob=0.
- block=16'h00F0 (horizontal I), pos (17,0), rot 0 → oob=1, fit=0. Same stimulus with rot 1 (vertical, column x=2 → fx=19) → fit=1.
- O piece at pos (-1,-2) on an empty field → fit=1, because mask column 0 is empty and row fy=-1 counts as free. O piece at pos (0,18) → row fy=20 gives oob=1.
- Pulse start again during SCAN with different operands → ignored; done appears once, with the result for the first operands.
- Assert rst_n=0 at cycle 2 of a scan → busy=0 and done=0 immediately; no done pulse afterwards; a fresh start completes normally.
